// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache: FSM states,
// address field widths and the byte-strobe merge.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    // Widest word the merge helper handles; callers cast to their own XLEN.
    localparam int MAX_XLEN  = 64;
    localparam int MAX_STRB  = MAX_XLEN / 8;

    function automatic int NOFFSET(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int NINDEX(input int nsets);
        return $clog2(nsets);
    endfunction

    function automatic int NTAG(input int xlen, input int nsets, input int line_words);
        return xlen - $clog2(xlen / 8) - NINDEX(nsets) - NOFFSET(line_words);
    endfunction

    function automatic logic [MAX_XLEN-1:0] merge_bytes(
        input logic [MAX_XLEN-1:0] word,
        input logic [MAX_XLEN-1:0] wdata,
        input logic [MAX_STRB-1:0] wstrb
    );
        logic [MAX_XLEN-1:0] res;
        res = word;
        for (int b = 0; b < MAX_STRB; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// Per-way tag, valid, dirty and line storage for one cache. All ways of the
// addressed set are read combinationally; one way is written per cycle.
module cache_way_array
    import cache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NWAYS      = 4,
    parameter int NSETS      = 64,
    parameter int LINE_WORDS = 4,
    localparam int NIDX      = NINDEX(NSETS),
    localparam int NTAGW     = NTAG(XLEN, NSETS, LINE_WORDS),
    localparam int NOFF      = NOFFSET(LINE_WORDS),
    localparam int OFFW      = (NOFF > 0) ? NOFF : 1,
    localparam int WAYW      = (NWAYS > 1) ? $clog2(NWAYS) : 1,
    localparam int LINEW     = LINE_WORDS * XLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NIDX-1:0]        index,
    output logic [NWAYS*NTAGW-1:0] rd_tags,
    output logic [NWAYS*LINEW-1:0] rd_lines,
    output logic [NWAYS-1:0]       rd_valid,
    output logic [NWAYS-1:0]       rd_dirty,
    input  logic [WAYW-1:0]        wr_way,
    input  logic                   fill_en,
    input  logic [NTAGW-1:0]       fill_tag,
    input  logic [LINEW-1:0]       fill_line,
    input  logic                   word_en,
    input  logic [OFFW-1:0]        word_off,
    input  logic [XLEN-1:0]        word_data,
    input  logic                   clean_en
);

    logic [NWAYS-1:0] valid_q [NSETS];
    logic [NWAYS-1:0] dirty_q [NSETS];
    logic [NTAGW-1:0] tag_q   [NWAYS][NSETS];
    logic [LINEW-1:0] line_q  [NWAYS][NSETS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (fill_en) begin
                valid_q[index][wr_way] <= 1'b1;
                dirty_q[index][wr_way] <= 1'b0;
            end else if (word_en) begin
                dirty_q[index][wr_way] <= 1'b1;
            end else if (clean_en) begin
                dirty_q[index][wr_way] <= 1'b0;
            end
        end
    end

    // Tags and data are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[wr_way][index]  <= fill_tag;
            line_q[wr_way][index] <= fill_line;
        end else if (word_en) begin
            line_q[wr_way][index][word_off*XLEN +: XLEN] <= word_data;
        end
    end

    for (genvar w = 0; w < NWAYS; w++) begin : g_rd
        assign rd_tags[w*NTAGW +: NTAGW]  = tag_q[w][index];
        assign rd_lines[w*LINEW +: LINEW] = line_q[w][index];
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with a miss FSM
// that writes back a dirty victim and refills the line over a valid/ready bus.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NWAYS      = 4,
    parameter int NSETS      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [XLEN-1:0]            req_addr,
    input  logic [XLEN-1:0]            req_wdata,
    input  logic [XLEN/8-1:0]          req_wstrb,
    output logic                       resp_valid,
    output logic [XLEN-1:0]            resp_rdata,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [XLEN-1:0]            mem_req_addr,
    output logic [LINE_WORDS*XLEN-1:0] mem_wdata,
    input  logic                       mem_resp_valid,
    input  logic [LINE_WORDS*XLEN-1:0] mem_rdata
);

    localparam int BYTEB   = $clog2(XLEN / 8);
    localparam int NOFF    = NOFFSET(LINE_WORDS);
    localparam int NIDX    = NINDEX(NSETS);
    localparam int NTAGW   = NTAG(XLEN, NSETS, LINE_WORDS);
    localparam int OFFW    = (NOFF > 0) ? NOFF : 1;
    localparam int WAYW    = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int LINEW   = LINE_WORDS * XLEN;
    localparam int LINE_SH = BYTEB + NOFF;

    state_t state_q, state_d;

    logic              req_write_q;
    logic [NTAGW-1:0]  req_tag_q;
    logic [NIDX-1:0]   req_idx_q;
    logic [OFFW-1:0]   req_off_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [XLEN/8-1:0] req_wstrb_q;

    logic [WAYW-1:0]   victim_q;
    logic              victim_by_ptr_q;
    logic              victim_load;
    logic [WAYW-1:0]   rr_ptr_q [NSETS];

    logic [NWAYS*NTAGW-1:0] rd_tags;
    logic [NWAYS*LINEW-1:0] rd_lines;
    logic [NWAYS-1:0]       rd_valid;
    logic [NWAYS-1:0]       rd_dirty;

    logic            fill_en, word_en, clean_en;
    logic [WAYW-1:0] wr_way;

    logic [NWAYS-1:0] hit_vec;
    logic             hit;
    logic [WAYW-1:0]  hit_way;
    logic [WAYW-1:0]  inv_way;
    logic             all_valid;
    logic [WAYW-1:0]  miss_victim;
    logic [LINEW-1:0] sel_line;
    logic [XLEN-1:0]  sel_word;
    logic [XLEN-1:0]  merged;
    logic [LINEW-1:0] victim_line;
    logic [NTAGW-1:0] victim_tag;

    cache_way_array #(
        .XLEN       (XLEN),
        .NWAYS      (NWAYS),
        .NSETS      (NSETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_ways (
        .clock     (clock),
        .reset     (reset),
        .index     (req_idx_q),
        .rd_tags   (rd_tags),
        .rd_lines  (rd_lines),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .wr_way    (wr_way),
        .fill_en   (fill_en),
        .fill_tag  (req_tag_q),
        .fill_line (mem_rdata),
        .word_en   (word_en),
        .word_off  (req_off_q),
        .word_data (merged),
        .clean_en  (clean_en)
    );

    // Request capture: data registers, loaded only on acceptance.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && req_valid) begin
            req_write_q <= req_write;
            req_off_q   <= OFFW'((req_addr >> BYTEB) & XLEN'(LINE_WORDS - 1));
            req_idx_q   <= NIDX'(req_addr >> LINE_SH);
            req_tag_q   <= NTAGW'(req_addr >> (LINE_SH + NIDX));
            req_wdata_q <= req_wdata;
            req_wstrb_q <= req_wstrb;
        end
    end

    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        inv_way   = '0;
        all_valid = &rd_valid;
        for (int w = 0; w < NWAYS; w++) begin
            hit_vec[w] = rd_valid[w] && (rd_tags[w*NTAGW +: NTAGW] == req_tag_q);
            if (hit_vec[w]) hit_way = WAYW'(w);
        end
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) inv_way = WAYW'(w);
        end
    end

    assign hit         = |hit_vec;
    assign miss_victim = all_valid ? rr_ptr_q[req_idx_q] : inv_way;
    assign sel_line    = rd_lines[hit_way*LINEW +: LINEW];
    assign sel_word    = sel_line[req_off_q*XLEN +: XLEN];
    assign merged      = req_write_q
                       ? XLEN'(merge_bytes(MAX_XLEN'(sel_word), MAX_XLEN'(req_wdata_q),
                                           MAX_STRB'(req_wstrb_q)))
                       : sel_word;
    assign victim_line = rd_lines[victim_q*LINEW +: LINEW];
    assign victim_tag  = rd_tags[victim_q*NTAGW +: NTAGW];

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        fill_en       = 1'b0;
        word_en       = 1'b0;
        clean_en      = 1'b0;
        wr_way        = victim_q;
        victim_load   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_rdata = merged;
                    wr_way     = hit_way;
                    word_en    = req_write_q;
                    state_d    = IDLE;
                end else begin
                    victim_load = 1'b1;
                    state_d     = (rd_valid[miss_victim] && rd_dirty[miss_victim])
                                ? WRITEBACK : FILL_REQ;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = XLEN'({victim_tag, req_idx_q}) << LINE_SH;
                mem_wdata     = victim_line;
                if (mem_req_ready) begin
                    clean_en = 1'b1;
                    state_d  = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = XLEN'({req_tag_q, req_idx_q}) << LINE_SH;
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en = 1'b1;
                    state_d = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pointer only moves when it actually picked the victim, so invalid
    // ways are consumed first without disturbing the round-robin order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            victim_q        <= '0;
            victim_by_ptr_q <= 1'b0;
            for (int s = 0; s < NSETS; s++) rr_ptr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (victim_load) begin
                victim_q        <= miss_victim;
                victim_by_ptr_q <= all_valid;
            end
            if (fill_en && victim_by_ptr_q && NWAYS > 1) begin
                rr_ptr_q[req_idx_q] <= rr_ptr_q[req_idx_q] + WAYW'(1);
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed scenarios plus random traffic checked
// against a flat word-addressed memory model and a simple memory agent.
module tb_set_assoc_cache;

    localparam int XLEN       = 32;
    localparam int NWAYS      = 4;
    localparam int NSETS      = 64;
    localparam int LINE_WORDS = 4;
    localparam int LINEW      = LINE_WORDS * XLEN;

    logic             clock;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [3:0]       req_wstrb;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_rdata;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_write;
    logic [XLEN-1:0]  mem_req_addr;
    logic [LINEW-1:0] mem_wdata;
    logic             mem_resp_valid;
    logic [LINEW-1:0] mem_rdata;

    set_assoc_cache #(
        .XLEN       (XLEN),
        .NWAYS      (NWAYS),
        .NSETS      (NSETS),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Memory agent configuration (written by the main sequence only).
    int stall_cycles = 0;
    int fill_lat     = 1;
    bit inject_resp  = 1'b0;

    // Memory agent observations (written by the agent only).
    int               n_rd = 0;
    int               n_wr = 0;
    int               resp_cnt = 0;
    int               stab_err = 0;
    logic [31:0]      last_wb_addr = '0;
    logic [31:0]      last_fill_addr = '0;
    logic [LINEW-1:0] last_wb_data = '0;
    bit               pend = 1'b0;
    int               delay = 0;
    int               hold = 0;
    logic [31:0]      pend_addr = '0;
    logic [31:0]      snap_addr = '0;
    logic             snap_wr = 1'b0;
    logic [LINEW-1:0] snap_data = '0;

    logic [LINEW-1:0] backing [logic [31:0]];
    logic [31:0]      ref_mem [logic [31:0]];

    localparam logic [31:0] WA = 32'hA0A0_A0A0;
    localparam logic [31:0] WB = 32'h1122_3344;
    localparam logic [31:0] WC = 32'hC0C0_C0C0;
    localparam logic [31:0] WD = 32'hD0D0_D0D0;

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        case (wa)
            32'h0000_1000: return WA;
            32'h0000_1004: return WB;
            32'h0000_1008: return WC;
            32'h0000_100C: return WD;
            default:       return {~wa[15:0], wa[15:0] ^ 16'h5A5A};
        endcase
    endfunction

    function automatic logic [LINEW-1:0] line_data(input logic [31:0] la);
        logic [LINEW-1:0] r;
        if (backing.exists(la)) return backing[la];
        for (int k = 0; k < LINE_WORDS; k++) r[32*k +: 32] = init_word(la + 32'(4 * k));
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory agent: stalls ready, records write-backs, returns fills after a latency.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clock);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_valid) resp_cnt++;
            if (inject_resp) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = {4{32'hDEAD_BEEF}};
            end else if (reset) begin
                pend = 1'b0;
                hold = 0;
            end else if (pend) begin
                if (delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = line_data(pend_addr);
                    pend           = 1'b0;
                end else begin
                    delay--;
                end
            end else if (mem_req_valid) begin
                if (hold > 0 && (mem_req_addr !== snap_addr || mem_req_write !== snap_wr
                                 || mem_wdata !== snap_data)) stab_err++;
                snap_addr = mem_req_addr;
                snap_wr   = mem_req_write;
                snap_data = mem_wdata;
                if (hold < stall_cycles) begin
                    hold++;
                end else begin
                    mem_req_ready = 1'b1;
                    hold          = 0;
                    if (mem_req_write) begin
                        n_wr++;
                        last_wb_addr          = mem_req_addr;
                        last_wb_data          = mem_wdata;
                        backing[mem_req_addr] = mem_wdata;
                    end else begin
                        n_rd++;
                        last_fill_addr = mem_req_addr;
                        pend_addr      = mem_req_addr;
                        pend           = 1'b1;
                        delay          = fill_lat;
                    end
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("req_ready_before_req", 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        check("resp_arrives", 128'(resp_valid), 128'(1'b1));
        rdata = resp_rdata;
        @(negedge clock);
        check("resp_single_pulse", 128'(resp_valid), 128'(1'b0));
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input string tag,
                          output logic [31:0] rdata, output int lat);
        logic [31:0] wa, exp;
        wa  = addr & 32'hFFFF_FFFC;
        exp = wr ? merge32(ref_read(wa), wdata, strb) : ref_read(wa);
        do_req(wr, addr, wdata, strb, rdata, lat);
        if (wr) ref_mem[wa] = exp;
        check(tag, 128'(rdata), 128'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, r0, w0, rc, guard;
        logic [31:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(negedge clock);
        check("reset_req_ready", 128'(req_ready), 128'(1'b0));
        check("reset_mem_req_valid", 128'(mem_req_valid), 128'(1'b0));
        check("reset_resp_valid", 128'(resp_valid), 128'(1'b0));
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_req_ready", 128'(req_ready), 128'(1'b1));

        // Cold clean miss.
        fill_lat = 2;
        r0 = n_rd; w0 = n_wr;
        access(1'b0, 32'h0000_1004, '0, '0, "cold_load_data", rd, lat);
        check("cold_load_word_b", 128'(rd), 128'(WB));
        check("cold_fill_count", 128'(n_rd - r0), 128'(1));
        check("cold_no_writeback", 128'(n_wr - w0), 128'(0));
        check("cold_fill_addr", 128'(last_fill_addr), 128'(32'h0000_1000));

        // Hit latency.
        r0 = n_rd; w0 = n_wr;
        access(1'b0, 32'h0000_1004, '0, '0, "hit_load_data", rd, lat);
        check("hit_latency", 128'(lat), 128'(1));
        check("hit_no_mem_traffic", 128'(n_rd - r0 + n_wr - w0), 128'(0));

        // Store hit with strobes, then read back.
        access(1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011, "store_resp_data", rd, lat);
        check("store_resp_word", 128'(rd), 128'(32'h1122_CCDD));
        check("store_hit_latency", 128'(lat), 128'(1));
        access(1'b0, 32'h0000_1004, '0, '0, "load_after_store", rd, lat);
        check("load_after_store_word", 128'(rd), 128'(32'h1122_CCDD));

        // Fill the remaining ways of set 0, then evict the dirty line with stalls.
        w0 = n_wr;
        access(1'b0, 32'h0000_1400, '0, '0, "evict_load_1400", rd, lat);
        access(1'b0, 32'h0000_1800, '0, '0, "evict_load_1800", rd, lat);
        access(1'b0, 32'h0000_1C00, '0, '0, "evict_load_1c00", rd, lat);
        check("no_wb_while_ways_free", 128'(n_wr - w0), 128'(0));
        stall_cycles = 5;
        r0 = n_rd;
        access(1'b0, 32'h0000_2000, '0, '0, "evict_load_2000", rd, lat);
        stall_cycles = 0;
        check("evict_one_writeback", 128'(n_wr - w0), 128'(1));
        check("evict_one_fill", 128'(n_rd - r0), 128'(1));
        check("evict_wb_addr", 128'(last_wb_addr), 128'(32'h0000_1000));
        check("evict_wb_data", last_wb_data, {WD, WC, 32'h1122_CCDD, WA});
        check("stall_outputs_stable", 128'(stab_err), 128'(0));

        // The written-back line comes back from memory.
        r0 = n_rd; w0 = n_wr;
        access(1'b0, 32'h0000_1004, '0, '0, "reload_after_wb", rd, lat);
        check("reload_misses", 128'(n_rd - r0), 128'(1));
        check("reload_clean_victim", 128'(n_wr - w0), 128'(0));

        // Reset in FILL_WAIT, then a stale memory response.
        fill_lat = 40;
        r0 = n_rd;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3008;
        @(negedge clock);
        req_valid = 1'b0;
        guard = 0;
        while (n_rd == r0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("midfill_fill_issued", 128'(n_rd - r0), 128'(1));
        repeat (2) @(negedge clock);
        rc = resp_cnt;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        inject_resp = 1'b1;
        @(posedge clock);
        inject_resp = 1'b0;
        repeat (3) @(negedge clock);
        check("midfill_no_resp", 128'(resp_cnt - rc), 128'(0));
        check("midfill_idle_ready", 128'(req_ready), 128'(1'b1));
        check("midfill_no_mem_req", 128'(mem_req_valid), 128'(1'b0));
        fill_lat = 1;
        r0 = n_rd;
        access(1'b0, 32'h0000_1004, '0, '0, "post_reset_load_1004", rd, lat);
        check("post_reset_1004_misses", 128'(n_rd - r0), 128'(1));
        r0 = n_rd;
        access(1'b0, 32'h0000_3008, '0, '0, "post_reset_load_3008", rd, lat);
        check("post_reset_3008_misses", 128'(n_rd - r0), 128'(1));

        // Random loads/stores concentrated on two sets to force evictions.
        for (int i = 0; i < 150; i++) begin
            stall_cycles = int'($urandom_range(0, 2));
            fill_lat     = int'($urandom_range(0, 3));
            a = 32'h0000_4000 + 32'($urandom_range(0, 5)) * 32'h400
              + 32'($urandom_range(0, 1)) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4;
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
                   "random_access", rd, lat);
        end
        check("random_stall_stable", 128'(stab_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative write-back, write-allocate data cache between the core load/store unit and the memory bus.
- Adds over the previous tag-compare array:
  - valid and dirty tracking
  - per-set round-robin replacement
  - byte-strobed word writes
  - a miss FSM with dirty-victim write-back and line refill over a valid/ready memory handshake
- One outstanding request at a time.

Parameters:
- XLEN, 32, address and data word width in bits.
- NWAYS, 4, associativity; power of two, >= 1.
- NSETS, 64, number of sets; power of two, >= 2.
- LINE_WORDS, 4, XLEN-bit words per line; power of two, >= 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  cache accepts request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address; low log2(XLEN/8) bits ignored.
- req_wdata  in  XLEN  store data.
- req_wstrb  in  XLEN/8  store byte enables.
- resp_valid  out  1  one-cycle response pulse (loads and stores).
- resp_rdata  out  XLEN  load data; store responses return the post-write word.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = line write-back, 0 = line fill.
- mem_req_addr  out  XLEN  line-aligned address.
- mem_wdata  out  LINE_WORDS*XLEN  victim line data.
- mem_resp_valid  in  1  fill data valid (reads only; writes need no response).
- mem_rdata  in  LINE_WORDS*XLEN  fill line; word 0 in the LSBs.

Behaviour:
- Address split:
  - word offset = log2(LINE_WORDS) bits above the byte bits
  - index = log2(NSETS) bits next
  - tag = remaining MSBs
- Reset (async):
  - state IDLE
  - all valid, dirty and round-robin pointers cleared
  - outputs 0, except req_ready = 1 once reset deasserts
  - tag and data arrays are not reset
- Reset mid-transaction abandons it; no resp_valid for that request. A memory response arriving after reset is ignored.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture write, addr, wdata and wstrb into request registers, then go to LOOKUP.
  - req_ready = 0 in all other states.
- LOOKUP:
  - hit = valid && tag match in any way. More than one matching way cannot occur by construction.
  - Hit:
    - resp_valid = 1 this cycle; resp_rdata = selected word with strobed bytes merged.
    - A store writes the strobed bytes and sets dirty at the clock edge.
    - Next state IDLE.
  - Hit latency: resp_valid one cycle after acceptance. Peak throughput is one request per 2 cycles.
  - Miss, victim selection: the lowest-index invalid way; if every way is valid, the way at the set's round-robin pointer.
  - Miss, next state: WRITEBACK if the victim is valid and dirty, else FILL_REQ.
- WRITEBACK:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim tag, index, 0}; mem_wdata = victim line.
  - Outputs are held stable until mem_req_ready. On the handshake, clear victim dirty and go to FILL_REQ.
- FILL_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_req_addr = request line address.
  - On mem_req_ready, go to FILL_WAIT.
- FILL_WAIT:
  - On mem_resp_valid, install line, tag, valid = 1, dirty = 0.
  - Advance the set's pointer (mod NWAYS) only if the victim was chosen by the pointer.
  - Go to LOOKUP, which then hits and completes the original request. Miss latency = fill latency + handshakes + 2 cycles.
- mem_req_valid is never dropped before ready. mem_resp_valid outside FILL_WAIT is ignored.
- NWAYS = 1: the pointer is always 0 (direct-mapped).

Decomposition:
- cache_pkg holds:
  - state enum
  - field-width functions: NOFFSET, NINDEX, NTAG from the parameters
  - byte-merge function (word, wdata, wstrb)
- One sub-module: cache_way_array (per-way tag, valid, dirty and line storage, with a write port and indexed read).
- The top module holds the FSM, hit/victim logic and the pointers.

Test Plan:
- Cold miss, clean:
  - Stimulus: load 0x0000_1004 after reset.
  - Required: FILL_REQ with mem_req_addr 0x0000_1000, write = 0. After fill with words {A,B,C,D}, resp_rdata = B. No WRITEBACK.
- Hit latency:
  - Stimulus: repeat the load 0x0000_1004.
  - Required: resp_valid exactly 1 cycle after acceptance, rdata B, no mem_req_valid.
- Store hit with strobe:
  - Stimulus: store 0xAABBCCDD, wstrb 4'b0011 to 0x0000_1004 (old word 0x11223344).
  - Required: response word 0x1122CCDD; a following load returns 0x1122CCDD; line dirty.
- Dirty eviction, NWAYS = 4, NSETS = 64, LINE_WORDS = 4:
  - Stimulus: after the store above, load four other lines mapping to set 0 (stride 0x400: 0x1400, 0x1800, 0x1C00, 0x2000).
  - Required: the fourth fill is preceded by a write-back to 0x0000_1000 carrying the modified line.
- Handshake stalls:
  - Stimulus: mem_req_ready held low 5 cycles in WRITEBACK and FILL_REQ.
  - Required: mem_req_valid, addr and wdata stable throughout; exactly one write and one read issued.
- Reset mid-fill:
  - Stimulus: assert reset in FILL_WAIT, then drive mem_resp_valid.
  - Required: no resp_valid; every valid bit 0; the next load to the same address misses again.
